// File: rtl/spi_slave_if.sv
// Pin and fabric-side signal bundle for the mode-0 SPI responder.
interface spi_slave_if #(
    parameter int WIDTH = 8
);
    logic             sclk;
    logic             cs;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ack;
    logic             busy;
    logic             overrun;

    modport slave (
        input  sclk, cs, mosi,
        input  tx_data, tx_load, rx_ack,
        output miso, miso_oe, tx_ready,
        output rx_data, rx_valid, busy, overrun
    );

    modport master (
        output sclk, cs, mosi,
        output tx_data, tx_load, rx_ack,
        input  miso, miso_oe, tx_ready,
        input  rx_data, rx_valid, busy, overrun
    );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI responder, MSB first, oversampled on clk, with RX valid/ack
// and a one-deep TX buffer.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [WIDTH-1:0] r_tx_buf;
    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_buf_full;
    logic             r_rx_valid;
    logic             r_overrun;
    logic             r_miso;
    logic             r_word_done;
    logic [CW-1:0]    r_bit_cnt;

    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_cs_rise;
    logic             w_cs_fall;
    logic             w_mosi;
    logic             w_start;
    logic             w_rise;
    logic             w_fall;
    logic             w_last;
    logic             w_consume;
    logic [WIDTH-1:0] w_reload;

    // Edges come from the last sync stage against one extra delay flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_d;
    assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
    assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

    // A cs rise overrides any sclk edge in the same cycle.
    assign w_start   = (r_state == IDLE) && w_cs_fall;
    assign w_rise    = (r_state == SHIFT) && w_sclk_rise && !w_cs_rise;
    assign w_fall    = (r_state == SHIFT) && w_sclk_fall && !w_cs_rise;
    assign w_last    = w_rise && (r_bit_cnt == CW'(WIDTH - 1));
    assign w_consume = w_start || (w_fall && r_word_done);
    assign w_reload  = r_buf_full ? r_tx_buf : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_cs_fall) w_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A load into an empty buffer survives a same-cycle consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_buf   <= '0;
            r_buf_full <= 1'b0;
        end else if (w_consume && r_buf_full) begin
            r_buf_full <= 1'b0;
        end else if (bus.tx_load && !r_buf_full) begin
            r_tx_buf   <= bus.tx_data;
            r_buf_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            if (w_cs_rise) begin
                r_bit_cnt   <= '0;
                r_miso      <= 1'b0;
                r_word_done <= 1'b0;
            end else if (w_consume) begin
                r_tx_shift  <= w_reload;
                r_miso      <= w_reload[WIDTH-1];
                r_word_done <= 1'b0;
            end else if (w_fall) begin
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                r_miso     <= r_tx_shift[WIDTH-2];
            end
            if (w_start) begin
                r_bit_cnt <= '0;
            end
            if (w_rise) begin
                r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi};
                if (w_last) begin
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    // A completing word beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_last) begin
            r_rx_data  <= {r_rx_shift[WIDTH-2:0], w_mosi};
            r_rx_valid <= 1'b1;
            if (bus.rx_ack) begin
                r_overrun <= 1'b0;
            end else if (r_rx_valid) begin
                r_overrun <= 1'b1;
            end
        end else if (bus.rx_ack) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end
    end

    assign bus.miso     = r_miso;
    assign bus.miso_oe  = (r_state == SHIFT);
    assign bus.busy     = (r_state == SHIFT);
    assign bus.tx_ready = ~r_buf_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.overrun  = r_overrun;
endmodule
